// File: rtl/hht_pkg.sv
// Shared types and default sizing for the HHT gather controller.
package hht_pkg;

    localparam int unsigned HHT_DW    = 32;
    localparam int unsigned HHT_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Output group at the default sizing; the RTL packs {data, mask, last} in this order.
    typedef struct packed {
        logic [HHT_LANES*HHT_DW-1:0] data;
        logic [HHT_LANES-1:0]        mask;
        logic                        last;
    } group_t;

    function automatic int unsigned group_width(input int unsigned dw, input int unsigned lanes);
        return dw * lanes + lanes + 1;
    endfunction

endpackage

// File: rtl/hht_gather_fifo.sv
// Synchronous group FIFO; a push is accepted at full when a pop happens in the same cycle.
module hht_gather_fifo #(
    parameter int unsigned W     = 134,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/hht_gather_ctrl.sv
// Gathers v[v_base+col[i]] one element per cycle into LANES-wide groups behind a FIFO.
// Optional out-of-range lane zeroing and sticky err port: define HHT_BOUNDS_CHECK_EN.
module hht_gather_ctrl
    import hht_pkg::*;
#(
    parameter int unsigned DW         = HHT_DW,
    parameter int unsigned LANES      = HHT_LANES,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef HHT_BOUNDS_CHECK_EN
    ,
    parameter int unsigned VSIZE      = 32
`endif
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                start,
    input  logic [DW-1:0]       col_base,
    input  logic [DW-1:0]       v_base,
    input  logic [DW-1:0]       csize,
    output logic [DW-1:0]       addr1,
    input  logic [DW-1:0]       data1,
    output logic [DW-1:0]       addr2,
    input  logic [DW-1:0]       data2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*DW-1:0] out_data,
    output logic [LANES-1:0]    out_mask,
    output logic                out_last,
    output logic                busy,
    output logic                done
`ifdef HHT_BOUNDS_CHECK_EN
    ,
    output logic                err
`endif
);

    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned GW = group_width(DW, LANES);

    state_t          state_q, state_d;
    logic [DW-1:0]   addr1_q, addr1_d;
    logic [DW-1:0]   v_base_q, v_base_d;
    logic [DW-1:0]   csize_q, csize_d;
    logic [DW-1:0]   rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   lane_q [LANES];

    logic            last_el;
    logic            push_due;
    logic            stall;
    logic            capture;
    logic            push;
    logic [GW-1:0]   push_grp;
    logic [LANES*DW-1:0] grp_data;
    logic [LANES-1:0]    grp_mask;
    logic [DW-1:0]   cur_val;
    logic            fifo_full;
    logic            fifo_empty;
    logic [GW-1:0]   head;

`ifdef HHT_BOUNDS_CHECK_EN
    logic            oob;
    logic            err_q, err_d;

    assign oob     = (data1 >= DW'(VSIZE));
    assign cur_val = oob ? '0 : data2;
    assign err     = err_q;
`else
    assign cur_val = data2;
`endif

    assign last_el  = (rd_cnt_q == csize_q - DW'(1));
    assign push_due = (lane_cnt_q == LW'(LANES - 1)) || last_el;
    assign stall    = push_due && fifo_full && !out_ready;

    assign addr1     = addr1_q;
    assign addr2     = (state_q == FETCH) ? v_base_q + data1 : '0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = !fifo_empty;
    assign out_data  = head[GW-1 -: LANES*DW];
    assign out_mask  = head[LANES:1];
    assign out_last  = head[0];

    // Group being closed this cycle: earlier lanes from registers, current element bypassed.
    always_comb begin
        grp_data = '0;
        grp_mask = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (LW'(k) == lane_cnt_q) begin
                grp_data[k*DW +: DW] = cur_val;
                grp_mask[k]          = 1'b1;
            end else if (LW'(k) < lane_cnt_q) begin
                grp_data[k*DW +: DW] = lane_q[k];
                grp_mask[k]          = 1'b1;
            end
        end
    end

    // Next-state and register updates.
    always_comb begin
        state_d    = state_q;
        addr1_d    = addr1_q;
        v_base_d   = v_base_q;
        csize_d    = csize_q;
        rd_cnt_d   = rd_cnt_q;
        lane_cnt_d = lane_cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        capture    = 1'b0;
        push       = 1'b0;
        push_grp   = {grp_data, grp_mask, last_el};
`ifdef HHT_BOUNDS_CHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // done_q high means a job just ended; a start in that cycle is dropped.
                if (start && !done_q) begin
                    v_base_d   = v_base;
                    csize_d    = csize;
                    rd_cnt_d   = '0;
                    lane_cnt_d = '0;
                    busy_d     = 1'b1;
`ifdef HHT_BOUNDS_CHECK_EN
                    err_d      = 1'b0;
`endif
                    if (csize == '0) begin
                        push     = 1'b1;
                        push_grp = {(GW-1)'(0), 1'b1};
                        state_d  = DRAIN;
                    end else begin
                        addr1_d = col_base;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (!stall) begin
                    capture = 1'b1;
                    push    = push_due;
`ifdef HHT_BOUNDS_CHECK_EN
                    if (oob) err_d = 1'b1;
`endif
                    if (last_el) begin
                        addr1_d    = '0;
                        rd_cnt_d   = '0;
                        lane_cnt_d = '0;
                        state_d    = DRAIN;
                    end else begin
                        addr1_d    = addr1_q + DW'(1);
                        rd_cnt_d   = rd_cnt_q + DW'(1);
                        lane_cnt_d = push_due ? '0 : lane_cnt_q + LW'(1);
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            addr1_q    <= '0;
            v_base_q   <= '0;
            csize_q    <= '0;
            rd_cnt_q   <= '0;
            lane_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef HHT_BOUNDS_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr1_q    <= addr1_d;
            v_base_q   <= v_base_d;
            csize_q    <= csize_d;
            rd_cnt_q   <= rd_cnt_d;
            lane_cnt_q <= lane_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef HHT_BOUNDS_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int k = 0; k < int'(LANES); k++) lane_q[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (lane_cnt_q == LW'(k)) lane_q[k] <= cur_val;
            end
        end
    end

    hht_gather_fifo #(
        .W     (GW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Rst),
        .push      (push),
        .push_data (push_grp),
        .pop       (out_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_hht_gather_ctrl.sv
// Directed bench for hht_gather_ctrl with combinational two-port memory model.
module tb_hht_gather_ctrl;
    import hht_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 4;

    logic                Clk;
    logic                Rst;
    logic                start;
    logic [DW-1:0]       col_base, v_base, csize;
    logic [DW-1:0]       addr1, data1, addr2, data2;
    logic                out_valid, out_ready;
    logic [LANES*DW-1:0] out_data;
    logic [LANES-1:0]    out_mask;
    logic                out_last, busy, done;
`ifdef HHT_BOUNDS_CHECK_EN
    logic                err;
`endif

    hht_gather_ctrl #(
        .DW         (DW),
        .LANES      (LANES),
        .FIFO_DEPTH (4)
`ifdef HHT_BOUNDS_CHECK_EN
        ,
        .VSIZE      (32)
`endif
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .start     (start),
        .col_base  (col_base),
        .v_base    (v_base),
        .csize     (csize),
        .addr1     (addr1),
        .data1     (data1),
        .addr2     (addr2),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
`ifdef HHT_BOUNDS_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int unsigned col_mem [102];
    int unsigned vec_mem [32];

    function automatic logic [31:0] rd1(input logic [31:0] a);
        if (a >= 32'd340 && a <= 32'd441) return col_mem[int'(a - 32'd340)];
        return 32'd99999;
    endfunction

    function automatic logic [31:0] rd2(input logic [31:0] a);
        if (a >= 32'd2 && a <= 32'd33) return vec_mem[int'(a - 32'd2)];
        return 32'd99999;
    endfunction

    always_comb data1 = rd1(addr1);
    always_comb data2 = rd2(addr2);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [LANES*DW-1:0] got_data [$];
    logic [LANES-1:0]    got_mask [$];
    logic                got_last [$];
    logic [31:0]         a2_log [4];
    logic [31:0]         a1_19, a1_20;
    int                  first_valid;
    int                  ndone;
    logic                busy_after;

    function automatic logic [LANES*DW-1:0] gd(input int i);
        if (i >= 0 && i < got_data.size()) return got_data[i];
        return '1;
    endfunction
    function automatic logic [LANES-1:0] gm(input int i);
        if (i >= 0 && i < got_mask.size()) return got_mask[i];
        return '1;
    endfunction
    function automatic logic gl(input int i);
        if (i >= 0 && i < got_last.size()) return got_last[i];
        return 1'bx;
    endfunction

    // Start a job and collect popped groups until done (bounded); optional abort or extra starts.
    task automatic run_job(input logic [31:0] cb, input logic [31:0] vb, input logic [31:0] cs,
                           input int hold, input int extra_start, input int abort_at,
                           input bit start_on_done);
        got_data.delete();
        got_mask.delete();
        got_last.delete();
        for (int i = 0; i < 4; i++) a2_log[i] = '0;
        a1_19 = '0;
        a1_20 = '0;
        first_valid = -1;
        ndone = 0;
        busy_after = 1'b1;
        @(negedge Clk);
        col_base  = cb;
        v_base    = vb;
        csize     = cs;
        start     = 1'b1;
        out_ready = (hold == 0);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge Clk);
            start     = (cyc == extra_start);
            out_ready = (cyc >= hold);
            if (cyc == abort_at) begin
                #2 Rst = 1'b0;
                return;
            end
            if (cyc < 4) a2_log[cyc] = addr2;
            if (cyc == 19) a1_19 = addr1;
            if (cyc == 20) a1_20 = addr1;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_mask.push_back(out_mask);
                got_last.push_back(out_last);
            end
            if (done) begin
                ndone++;
                start = start_on_done;
                break;
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (i == 0) busy_after = busy;
            start = 1'b0;
            if (done) ndone++;
        end
    endtask

    function automatic logic [31:0] exp_val(input int j, input logic [31:0] vb);
`ifdef HHT_BOUNDS_CHECK_EN
        if (col_mem[j] >= 32) return '0;
`endif
        return rd2(vb + col_mem[j]);
    endfunction

    // Reference grouping from the memory tables, compared against every collected group.
    task automatic check_model(input string tag, input logic [31:0] vb, input int cs);
        int ng;
        int bad;
        group_t eg;
        ng  = (cs == 0) ? 1 : (cs + int'(LANES) - 1) / int'(LANES);
        bad = 0;
        check({tag, "_ngroups"}, got_data.size(), ng);
        for (int g = 0; g < ng; g++) begin
            eg = '0;
            for (int k = 0; k < int'(LANES); k++) begin
                if (g * int'(LANES) + k < cs) begin
                    eg.data[k*DW +: DW] = exp_val(g * int'(LANES) + k, vb);
                    eg.mask[k]          = 1'b1;
                end
            end
            eg.last = (g == ng - 1);
            if ({gd(g), gm(g), gl(g)} !== eg) bad++;
        end
        check({tag, "_groups_bad"}, bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) vec_mem[i] = 100 + i;
        vec_mem[2]  = 60;
        vec_mem[5]  = 44;
        vec_mem[6]  = 40;
        vec_mem[11] = 71;
        vec_mem[24] = 84;
        vec_mem[30] = 86;
        for (int j = 0; j < 102; j++) col_mem[j] = (j * 7 + 3) % 32;
        col_mem[0]   = 11;
        col_mem[1]   = 2;
        col_mem[2]   = 6;
        col_mem[3]   = 24;
        col_mem[4]   = 5;
        col_mem[100] = 30;
        col_mem[101] = 24;

        Rst = 1'b0;
        start = 1'b0;
        col_base = '0;
        v_base = '0;
        csize = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", {addr1, addr2}, 0);
        check("rst_data_mask", {out_data, out_mask, out_last, done}, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b1;

        // T1: full job, consumer always ready
        run_job(32'd340, 32'd2, 32'd102, 0, -1, -1, 1'b0);
        check("t1_addr2_first4", {a2_log[0], a2_log[1], a2_log[2], a2_log[3]},
              {32'd13, 32'd4, 32'd8, 32'd26});
        check("t1_first_valid_cyc", first_valid, LANES);
        check("t1_g0_data", gd(0), {32'd84, 32'd40, 32'd60, 32'd71});
        check("t1_g0_mask_last", {gm(0), gl(0)}, {4'b1111, 1'b0});
        check("t1_glast_data", gd(25), {32'd0, 32'd0, 32'd84, 32'd86});
        check("t1_glast_mask_last", {gm(25), gl(25)}, {4'b0011, 1'b1});
        check("t1_done_pulses", ndone, 1);
        check("t1_busy_after", busy_after, 0);
        check("t1_idle_addr", {addr1, addr2}, 0);
        check_model("t1", 32'd2, 102);

        // T2: 20 cycles of backpressure
        run_job(32'd340, 32'd2, 32'd102, 20, -1, -1, 1'b0);
        check("t2_addr1_frozen_19", a1_19, 32'd359);
        check("t2_addr1_frozen_20", a1_20, 32'd359);
        check("t2_done_pulses", ndone, 1);
        check_model("t2", 32'd2, 102);

        // T3: empty job; start coinciding with done is dropped
        run_job(32'd340, 32'd2, 32'd0, 0, -1, -1, 1'b1);
        check("t3_group", {gd(0), gm(0), gl(0)}, {128'd0, 4'b0000, 1'b1});
        check("t3_ngroups", got_data.size(), 1);
        check("t3_done_pulses", ndone, 1);
        check("t3_start_on_done_ignored", busy_after, 0);

        // T4: asynchronous reset mid-FETCH, then rerun T1
        run_job(32'd340, 32'd2, 32'd102, 0, -1, 40, 1'b0);
        #1;
        check("t4_rst_valid_busy", {out_valid, busy, done, out_last, out_mask}, 0);
        check("t4_rst_addr", {addr1, addr2}, 0);
        check("t4_rst_data", out_data, 0);
        @(negedge Clk);
        Rst = 1'b1;
        run_job(32'd340, 32'd2, 32'd102, 0, -1, -1, 1'b0);
        check("t4_rerun_g0", gd(0), {32'd84, 32'd40, 32'd60, 32'd71});
        check("t4_rerun_done", ndone, 1);
        check_model("t4", 32'd2, 102);

        // T5: short job with start pulsed while busy
        run_job(32'd340, 32'd2, 32'd5, 0, 2, -1, 1'b0);
        check("t5_g0", {gd(0), gm(0), gl(0)}, {32'd84, 32'd40, 32'd60, 32'd71, 4'b1111, 1'b0});
        check("t5_g1", {gd(1), gm(1), gl(1)}, {96'd0, 32'd44, 4'b0001, 1'b1});
        check("t5_ngroups", got_data.size(), 2);
        check("t5_done_pulses", ndone, 1);

`ifdef HHT_BOUNDS_CHECK_EN
        // T6: one out-of-range column index
        col_mem[5] = 32;
        run_job(32'd340, 32'd2, 32'd8, 0, -1, -1, 1'b0);
        check("t6_g1_lane1_zero", gd(1)[63:32], 32'd0);
        check("t6_g1_lane0", gd(1)[31:0], 32'd44);
        check("t6_g0_intact", gd(0), {32'd84, 32'd40, 32'd60, 32'd71});
        check("t6_err_set", err, 1);
        repeat (5) @(negedge Clk);
        check("t6_err_sticky", err, 1);
        col_mem[5] = (5 * 7 + 3) % 32;
        run_job(32'd340, 32'd2, 32'd5, 0, -1, -1, 1'b0);
        check("t6_err_cleared_by_start", err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
